// File: rtl/demux1x2_striper_pkg.sv
// Shared constants for the 1:2 byte striper and its lane buffers.
// Build option DEMUX_PARITY_EN widens each lane entry by one stored parity bit.
package demux_pkg;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned LANE_DEPTH = 2;
    localparam int unsigned LANE0      = 0;
    localparam int unsigned LANE1      = 1;
endpackage

// File: rtl/demux1x2_striper_lane_fifo2.sv
// Two-entry lane buffer: 1-bit wrapping pointers, 2-bit occupancy count.
// Head is presented combinationally and reads as zero while the buffer is empty.
module lane_fifo2
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [LANE_DEPTH];
    logic [WIDTH-1:0] mem_d [LANE_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == 2'(LANE_DEPTH));
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/demux1x2_striper.sv
// 1:2 byte striper: accepted bytes alternate lane 0, lane 1 into two 2-entry buffers.
// Define DEMUX_PARITY_EN to add parity_out, parity captured per entry at push time.
module demux1x2_striper
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [1:0]        valid_out,
    input  logic [1:0]        ready_in
`ifdef DEMUX_PARITY_EN
    ,
    output logic [1:0]        parity_out
`endif
);

`ifdef DEMUX_PARITY_EN
    localparam int unsigned ENTRY_W = DATA_W + 1;
`else
    localparam int unsigned ENTRY_W = DATA_W;
`endif

    logic               sel_q, sel_d;
    logic               accept;
    logic [1:0]         full, empty, push, pop;
    logic [1:0]         lane_cnt [2];
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] lane_dout [2];

    // No bypass: a full target lane blocks input even if it pops this cycle.
    assign ready_out = !full[sel_q];
    assign accept    = valid_in && ready_out;

    always_comb begin
        sel_d       = sel_q ^ accept;
        push        = '0;
        push[LANE0] = accept && (sel_q == 1'b0);
        push[LANE1] = accept && (sel_q == 1'b1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign pop = ready_in & ~empty;

`ifdef DEMUX_PARITY_EN
    assign entry_in = {^in, in};
    // Empty lanes read back all-zero, so the stored parity bit drops to 0 too.
    assign parity_out = {lane_dout[LANE1][DATA_W], lane_dout[LANE0][DATA_W]};
`else
    assign entry_in = in;
`endif

    assign out0 = lane_dout[LANE0][DATA_W-1:0];
    assign out1 = lane_dout[LANE1][DATA_W-1:0];
    assign valid_out = {(lane_cnt[LANE1] != 2'd0), (lane_cnt[LANE0] != 2'd0)};

    lane_fifo2 #(.WIDTH(ENTRY_W)) u_lane0 (
        .clk   (clk),
        .reset (reset),
        .push  (push[LANE0]),
        .pop   (pop[LANE0]),
        .din   (entry_in),
        .dout  (lane_dout[LANE0]),
        .full  (full[LANE0]),
        .empty (empty[LANE0]),
        .count (lane_cnt[LANE0])
    );

    lane_fifo2 #(.WIDTH(ENTRY_W)) u_lane1 (
        .clk   (clk),
        .reset (reset),
        .push  (push[LANE1]),
        .pop   (pop[LANE1]),
        .din   (entry_in),
        .dout  (lane_dout[LANE1]),
        .full  (full[LANE1]),
        .empty (empty[LANE1]),
        .count (lane_cnt[LANE1])
    );

endmodule

// File: tb/tb_demux1x2_striper.sv
// Self-checking bench for demux1x2_striper; reference model is a pair of byte queues.
// Build with DEMUX_PARITY_EN defined to exercise the parity output as well.
module tb_demux1x2_striper;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] out0, out1;
    logic [1:0] valid_out;
    logic [1:0] ready_in;
`ifdef DEMUX_PARITY_EN
    logic [1:0] parity_out;
`endif

    int n_cmp;
    int n_bad;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         msel;

    demux1x2_striper #(.DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .out0      (out0),
        .out1      (out1),
        .valid_out (valid_out),
        .ready_in  (ready_in)
`ifdef DEMUX_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_head0();
        return (q0.size() != 0) ? q0[0] : 8'h00;
    endfunction

    function automatic logic [7:0] m_head1();
        return (q1.size() != 0) ? q1[0] : 8'h00;
    endfunction

    function automatic logic m_ready();
        return msel ? (q1.size() < 2) : (q0.size() < 2);
    endfunction

    function automatic logic [1:0] m_valid();
        return {q1.size() != 0, q0.size() != 0};
    endfunction

    // One clock with the currently driven inputs; model follows the striping rules.
    task automatic cycle();
        bit         acc, p0, p1;
        logic [7:0] b;
        acc = valid_in && m_ready();
        p0  = ready_in[0] && (q0.size() != 0);
        p1  = ready_in[1] && (q1.size() != 0);
        b   = din;
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (msel) q1.push_back(b);
            else      q0.push_back(b);
            msel = !msel;
        end
        #1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        ready_in = 2'b00;
        din      = 8'h00;
        reset    = 1'b0;
        q0.delete();
        q1.delete();
        msel = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        valid_in = 1'b1;
        ready_in = 2'b00;
        din      = 8'hC3;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({valid_out, out0, out1} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b out0=%h out1=%h, want 00/00/00", valid_out, out0, out1);
        end
        n_cmp++;
        if (ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", ready_out);
        end
        do_reset();
        n_cmp++;
        if ({ready_out, valid_out} !== 3'b100) begin
            n_bad++;
            $display("FAIL post_release: got ready=%b valid=%b want 1/00", ready_out, valid_out);
        end
    endtask

    task automatic test_stripe();
        logic [7:0] bytes [4];
        logic [7:0] e0 [4];
        logic [7:0] e1 [4];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        e0    = '{8'h11, 8'h00, 8'h33, 8'h00};
        e1    = '{8'h00, 8'h22, 8'h00, 8'h44};
        do_reset();
        valid_in = 1'b1;
        ready_in = 2'b11;
        for (int i = 0; i < 4; i++) begin
            din = bytes[i];
            cycle();
            n_cmp++;
            if ({out0, out1} !== {e0[i], e1[i]}) begin
                n_bad++;
                $display("FAIL stripe[%0d]: got out0=%h out1=%h want %h %h", i, out0, out1, e0[i], e1[i]);
            end
        end
        valid_in = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        valid_in = 1'b1;
        ready_in = 2'b00;
        for (int i = 0; i < 6; i++) begin
            din = 8'hA0 + 8'(i);
            cycle();
        end
        n_cmp++;
        if ({ready_out, valid_out, out0, out1} !== {1'b0, 2'b11, 8'hA0, 8'hA1}) begin
            n_bad++;
            $display("FAIL bp_full: got ready=%b valid=%b out0=%h out1=%h want 0/11/a0/a1", ready_out, valid_out, out0, out1);
        end
        din      = 8'hA4;
        ready_in = 2'b01;
        cycle();
        n_cmp++;
        if ({ready_out, out0} !== {1'b1, 8'hA2}) begin
            n_bad++;
            $display("FAIL bp_pop: got ready=%b out0=%h want 1/a2", ready_out, out0);
        end
        ready_in = 2'b00;
        cycle();
        n_cmp++;
        if ({ready_out, out0, q0.size() == 2} !== {1'b0, 8'hA2, 1'b1}) begin
            n_bad++;
            $display("FAIL bp_accept: got ready=%b out0=%h want 0/a2", ready_out, out0);
        end
        ready_in = 2'b11;
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({out0, out1} !== {m_head0(), m_head1()}) begin
                n_bad++;
                $display("FAIL bp_drain[%0d]: got %h %h want %h %h", i, out0, out1, m_head0(), m_head1());
            end
        end
    endtask

    task automatic test_ordering();
        do_reset();
        valid_in = 1'b1;
        ready_in = 2'b10;
        for (int i = 0; i < 5; i++) begin
            din = 8'h50 + 8'(i);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            din = 8'h60 + 8'(i);
            cycle();
            n_cmp++;
            if ({ready_out, valid_out, out0, out1} !== {1'b0, 2'b01, 8'h50, 8'h00}) begin
                n_bad++;
                $display("FAIL order_block[%0d]: got ready=%b valid=%b out0=%h out1=%h want 0/01/50/00", i, ready_out, valid_out, out0, out1);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        valid_in = 1'b1;
        ready_in = 2'b00;
        for (int i = 0; i < 3; i++) begin
            din = 8'h70 + 8'(i);
            cycle();
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({valid_out, out0, out1} !== 18'h0) begin
            n_bad++;
            $display("FAIL async_flush: got valid=%b out0=%h out1=%h want 00/00/00", valid_out, out0, out1);
        end
        q0.delete();
        q1.delete();
        msel = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        din = 8'h5A;
        cycle();
        n_cmp++;
        if ({valid_out, out0, out1} !== {2'b01, 8'h5A, 8'h00}) begin
            n_bad++;
            $display("FAIL after_flush: got valid=%b out0=%h out1=%h want 01/5a/00", valid_out, out0, out1);
        end
    endtask

    task automatic test_valid_toggle();
        logic [7:0] b [3];
        b = '{8'h0F, 8'hFF, 8'hF0};
        do_reset();
        ready_in = 2'b00;
        for (int i = 0; i < 3; i++) begin
            valid_in = (i != 1);
            din      = b[i];
            cycle();
        end
        valid_in = 1'b0;
        n_cmp++;
        if ({valid_out, out0, out1, ready_out} !== {2'b11, 8'h0F, 8'hF0, 1'b1}) begin
            n_bad++;
            $display("FAIL valid_toggle: got valid=%b out0=%h out1=%h ready=%b want 11/0f/f0/1", valid_out, out0, out1, ready_out);
        end
    endtask

`ifdef DEMUX_PARITY_EN
    task automatic test_parity();
        do_reset();
        ready_in = 2'b00;
        valid_in = 1'b1;
        din      = 8'h07;
        cycle();
        din = 8'h03;
        cycle();
        valid_in = 1'b0;
        n_cmp++;
        if (parity_out !== 2'b01) begin
            n_bad++;
            $display("FAIL parity: got %b want 01", parity_out);
        end
    endtask
`endif

    task automatic test_random();
        logic [1:0] ep;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = 2'($urandom_range(0, 3));
            din      = 8'($urandom);
            cycle();
            n_cmp++;
            if ({ready_out, valid_out, out0, out1} !== {m_ready(), m_valid(), m_head0(), m_head1()}) begin
                n_bad++;
                $display("FAIL random[%0d]: got ready=%b valid=%b out0=%h out1=%h want %b %b %h %h",
                         i, ready_out, valid_out, out0, out1, m_ready(), m_valid(), m_head0(), m_head1());
            end
            ep = {^m_head1(), ^m_head0()};
`ifdef DEMUX_PARITY_EN
            n_cmp++;
            if (parity_out !== ep) begin
                n_bad++;
                $display("FAIL random_parity[%0d]: got %b want %b", i, parity_out, ep);
            end
`endif
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        msel  = 1'b0;
        test_reset();
        test_stripe();
        test_backpressure();
        test_ordering();
        test_reset_midstream();
        test_valid_toggle();
`ifdef DEMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux1x2_striper.md
DEMUX1X2_STRIPER -- requirements
Module: demux1x2_striper

Interface
REQ-001 Parameter: DATA_W, 8, byte width of input and both lane outputs.
REQ-002 Parameter: LANE_DEPTH, 2, entries per lane buffer; fixed at 2 in this revision.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: in  input  DATA_W  input byte stream.
REQ-006 Port: valid_in  input  1  in carries a byte this cycle.
REQ-007 Port: ready_out  output  1  block accepts the byte this cycle.
REQ-008 Port: out0 / out1  output  DATA_W  lane 0 / lane 1 head byte.
REQ-009 Port: valid_out  output  2  bit N set when lane N head is valid.
REQ-010 Port: ready_in  input  2  bit N set when lane N consumer takes its head this cycle.

Function
REQ-011 Accept = valid_in && ready_out; the block SHALL write exactly one byte per accept.
REQ-012 A 1-bit selector sel SHALL choose the target lane; it SHALL toggle on every accept and only on accept.
REQ-013 The first byte after reset SHALL go to lane 0, then strictly alternate 0,1,0,1 (inverse of the 2:1 lane merge).
REQ-014 ready_out SHALL equal !full[sel]; no full-lane bypass (pop and push on a full lane in one cycle do not enable acceptance).
REQ-015 Each lane SHALL be a 2-entry FIFO with 1-bit wrapping read/write pointers and a 2-bit count.
REQ-016 A pushed byte SHALL appear on outN no earlier than the next rising edge (min latency 1 cycle).
REQ-017 valid_out[N] SHALL equal (countN != 0); outN SHALL be the head entry when valid, 0 when empty.
REQ-018 Pop on lane N SHALL occur when valid_out[N] && ready_in[N]; ready_in with empty lane SHALL be ignored.
REQ-019 Simultaneous push and pop on a non-empty, non-full lane SHALL leave count unchanged and preserve byte order.
REQ-020 A stalled lane (ready_in[N]=0) SHALL not block the other lane except via sel ordering: when sel points at a full lane, ready_out=0 even if the other lane has room.
REQ-021 Byte order within each lane SHALL be FIFO; no byte SHALL be dropped or duplicated.

Reset
REQ-022 On reset low: sel=0, both counts=0, all pointers=0, valid_out=2'b00, out0=out1=0, ready_out=1 after reset release.
REQ-023 Reset asserted mid-stream SHALL flush both lanes immediately (asynchronous); buffered bytes are discarded.
REQ-024 Outputs SHALL hold reset values until the first rising edge after reset deasserts.

Configuration
REQ-025 Macro DEMUX_PARITY_EN: when defined, the block SHALL add output parity_out[1:0], bit N = even parity (XOR) of outN, 0 when lane N empty; parity SHALL be stored per entry at push time.
REQ-026 Without DEMUX_PARITY_EN the port and per-entry parity storage SHALL not exist; all other behaviour identical.

Structure
REQ-027 Shared package demux_pkg SHALL hold DATA_W default, LANE_DEPTH, lane index constants LANE0=0/LANE1=1.
REQ-028 The lane buffer SHALL be a sub-module lane_fifo2 (push, pop, data in/out, full, empty, count), instantiated twice.
REQ-029 Top level SHALL contain only sel logic, push steering, ready_out and parity generation.

Verification
REQ-030 Reset then in=0x11,0x22,0x33,0x44 with valid_in=1 and ready_in=2'b11 -> out0 shows 0x11 then 0x33, out1 shows 0x22 then 0x44, each 1 cycle after accept.
REQ-031 ready_in=2'b00, stream 0xA0..0xA5 -> 4 accepts (0xA0..0xA3), then ready_out=0 with sel=0; raising ready_in[0] one cycle -> 0xA0 popped, 0xA4 accepted next cycle.
REQ-032 ready_in=2'b10, lane 0 full, lane 1 empty -> ready_out=0, no byte reaches lane 1 (ordering rule).
REQ-033 Assert reset with 3 bytes buffered -> valid_out=0 immediately, next byte after release lands on lane 0.
REQ-034 valid_in toggling 1,0,1 with bytes 0x0F,0xFF,0xF0 -> only 0x0F (lane 0) and 0xF0 (lane 1) accepted; sel unchanged on idle cycle.
REQ-035 With DEMUX_PARITY_EN, push 0x07 to lane 0 -> parity_out[0]=1; push 0x03 to lane 1 -> parity_out[1]=0.
